serial_adder: RTL



---
 rtl/serial_adder.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder producing {cout,sum} = a + b + cin over
// WIDTH clock cycles using a single full_adder cell.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous reset, active high
//   start - begin an addition (accepted in IDLE or DONE)
//   a, b  - WIDTH-bit operands, captured on the accepted start edge
//   cin   - carry-in, captured on the accepted start edge
//   busy  - high while the addition is running
//   done  - one-cycle pulse when sum/cout hold a fresh result
//   sum   - registered result, held until the next completion
//   cout  - registered carry-out, held with sum

// full_adder: single-bit adder cell.
//   a, b, cin - addend bits and carry-in
//   s, co     - sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra, rb, rs;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s, co;
  logic [WIDTH:0]   rs_ext;
  logic [WIDTH-1:0] rs_next;

  full_adder u_fa (
    .a  (ra[0]),
    .b  (rb[0]),
    .cin(c),
    .s  (s),
    .co (co)
  );

  // New sum bit enters at the MSB; widening first keeps WIDTH=1 free of
  // an empty rs[WIDTH-1:1] slice.
  assign rs_ext  = {s, rs};
  assign rs_next = rs_ext[WIDTH:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_next;
          c   <= co;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= rs_next;
            cout  <= co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE only lasts a cycle
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
